vga_capture: RTL and testbench

//  Sink end of the 640x480 VGA link: samples hsync/vsync/valid/RGB in the pclk domain.

---
 rtl/vga_capture_pkg.sv | 24 ++
 rtl/vga_sync_edge.sv | 67 ++++++
 rtl/vga_capture.sv | 183 ++++++++++++++++++
 tb/tb_vga_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared 640x480 timing defaults, capture FSM encodings and a saturating
// counter helper used by the VGA capture front end.
package vga_capture_pkg;

  // 640x480 @ 60 Hz frame geometry
  localparam int H_TOTAL_640  = 800;
  localparam int V_TOTAL_480  = 525;
  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;

  // Capture FSM encodings
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  // All timing counters stick at CNT_MAX instead of wrapping, so a missing
  // sync pulse can never masquerade as a short, valid-looking interval.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input register stage for the VGA sink plus falling-edge detection of the
// (registered) sync lines.
//   pclk, reset         : pixel clock, async active-high reset
//   hsync, vsync        : raw active-low syncs
//   valid, rgb, err_clr : raw active-video flag, colour, error clear
//   valid_r, rgb_r, err_clr_r : registered copies
//   hs_fall, vs_fall    : one-cycle pulses, aligned with the registered data
module vga_sync_edge
  import vga_capture_pkg::*;
(
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [23:0] rgb,
  input  logic        err_clr,
  output logic        valid_r,
  output logic [23:0] rgb_r,
  output logic        err_clr_r,
  output logic        hs_fall,
  output logic        vs_fall
);

  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic        valid_q, valid_d, clr_q, clr_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    hs_d      = hsync;
    vs_d      = vsync;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    valid_d   = valid;
    rgb_d     = rgb;
    clr_d     = err_clr;
  end

  // Sync registers idle high so that reset release is not seen as a fall.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      valid_q   <= 1'b0;
      rgb_q     <= '0;
      clr_q     <= 1'b0;
    end else begin
      hs_q      <= hs_d;
      hs_prev_q <= hs_prev_d;
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
      valid_q   <= valid_d;
      rgb_q     <= rgb_d;
      clr_q     <= clr_d;
    end
  end

  assign valid_r   = valid_q;
  assign rgb_r     = rgb_q;
  assign err_clr_r = clr_q;
  assign hs_fall   = hs_prev_q & ~hs_q;
  assign vs_fall   = vs_prev_q & ~vs_q;

endmodule

// File: rtl/vga_capture.sv
// VGA sink: measures line/frame timing, locks after LOCK_FRAMES consecutive
// matching frames and then emits one write per active pixel.
//   pclk, reset            : pixel clock, async active-high reset
//   hsync, vsync, valid    : link syncs (active low) and active-video flag
//   vga_r/g/b              : colour channels
//   err_clr                : clears the sticky timing error
//   pix_we/x/y/data        : pixel write port, {r,g,b}
//   frame_start            : pulse per vsync fall
//   locked, err_timing     : lock status, sticky timing error
//   h_total_meas/v_total_meas : last measured line / frame length
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_640,
  parameter int V_TOTAL     = V_TOTAL_480,
  parameter int H_ACTIVE    = H_ACTIVE_640,
  parameter int V_ACTIVE    = V_ACTIVE_480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        err_clr,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        err_timing
);

  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic        valid_r, clr_r, hs_fall, vs_fall;
  logic [23:0] rgb_r;

  vga_sync_edge u_sync (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .rgb({vga_r, vga_g, vga_b}), .err_clr(err_clr),
    .valid_r(valid_r), .rgb_r(rgb_r), .err_clr_r(clr_r),
    .hs_fall(hs_fall), .vs_fall(vs_fall)
  );

  logic [1:0]  state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic [9:0]  h_cnt_q, h_cnt_d, l_cnt_q, l_cnt_d;
  logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [9:0]  h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        line_bad_q, line_bad_d;
  logic        pix_we_q, pix_we_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        frame_start_q, frame_start_d, locked_q, locked_d, err_q, err_d;
  logic [9:0]  h_len;
  logic        h_bad, frame_ok, err_now;

  always_comb begin
    h_len = sat_inc(h_cnt_q);
    h_bad = hs_fall & (h_len != H_TOT);
    // The line closed by a simultaneous hsync fall still belongs to the
    // frame that this vsync fall is closing.
    frame_ok = (l_cnt_q == V_TOT) & (y_cnt_q == V_ACT) & ~line_bad_q & ~h_bad;

    h_cnt_d    = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
    h_meas_d   = hs_fall ? h_len : h_meas_q;
    v_meas_d   = vs_fall ? l_cnt_q : v_meas_q;
    line_bad_d = vs_fall ? 1'b0 : (line_bad_q | h_bad);
    x_cnt_d    = hs_fall ? 10'd0 : (valid_r ? sat_inc(x_cnt_q) : x_cnt_q);

    l_cnt_d = l_cnt_q;
    if (vs_fall)      l_cnt_d = {9'd0, hs_fall};
    else if (hs_fall) l_cnt_d = sat_inc(l_cnt_q);

    y_cnt_d = y_cnt_q;
    if (vs_fall)                       y_cnt_d = 10'd0;
    else if (hs_fall && x_cnt_q != '0) y_cnt_d = sat_inc(y_cnt_q);

    state_d = state_q;
    good_d  = good_q;
    err_now = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (frame_ok) begin
            good_d = good_q + 3'd1;
            if (good_d == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        // h_cnt_q >= 1022 without a fall means h_cnt reaches 1023 this edge
        err_now = h_bad
                | (~hs_fall & (h_cnt_q >= CNT_MAX - 10'd1))
                | (~hs_fall & valid_r & (x_cnt_q >= H_ACT))
                | (vs_fall & ((l_cnt_q != V_TOT) | (y_cnt_q != V_ACT)));
        if (err_now) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    pix_we_d = (state_q == ST_LOCKED) & valid_r & (x_cnt_q < H_ACT)
             & (y_cnt_q < V_ACT) & ~err_now;
    pix_x_d    = pix_we_d ? x_cnt_q : pix_x_q;
    pix_y_d    = pix_we_d ? y_cnt_q : pix_y_q;
    pix_data_d = pix_we_d ? rgb_r : pix_data_q;

    frame_start_d = vs_fall;
    locked_d      = (state_d == ST_LOCKED);
    err_d         = err_now | (err_q & ~clr_r);  // set wins over clear
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      h_cnt_q       <= '0;
      l_cnt_q       <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      line_bad_q    <= 1'b0;
      pix_we_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      h_cnt_q       <= h_cnt_d;
      l_cnt_q       <= l_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      line_bad_q    <= line_bad_d;
      pix_we_q      <= pix_we_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign pix_we       = pix_we_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_data     = pix_data_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;
  assign err_timing   = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunken frame geometry
// (32x10 total, 16x6 active) so whole frames fit in a short run.
module tb_vga_capture;

  localparam int HT = 32, HA = 16, VT = 10, VA = 6, LF = 2;
  localparam int HS_W = 4, H_VSTART = 8, V_SYNC = 2, V_ASTART = 2;

  logic        pclk = 1'b0;
  logic        reset, hsync, vsync, valid, err_clr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_we, frame_start, locked, err_timing;
  logic [9:0]  pix_x, pix_y, h_total_meas, v_total_meas;
  logic [23:0] pix_data;

  always #5 pclk = ~pclk;

  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                .LOCK_FRAMES(LF)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .err_clr(err_clr),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas), .err_timing(err_timing)
  );

  int checks = 0, errors = 0;
  int cyc_n = 0, wr_cnt, wr_unlocked = 0, first_cyc, first_valid_cyc;
  int first_x, first_y, last_x, last_y, data_bad, fs_cnt, err_rise_cyc;
  int line_cyc0, stretch_fall_cyc, last_fall_cyc;
  logic err_prev = 1'b0, hs_prev_drv = 1'b1;

  task automatic reset_stats();
    wr_cnt = 0; first_cyc = -1; first_valid_cyc = -1; data_bad = 0;
    fs_cnt = 0; err_rise_cyc = -1; last_x = -1; last_y = -1;
  endtask

  // One clock: sample the outputs produced by the last edge, then drive the
  // inputs for the next edge.
  task automatic tick(input logic hs, input logic vs, input logic v,
                      input logic [23:0] rgb, input logic clr);
    @(negedge pclk);
    cyc_n++;
    if (pix_we) begin
      wr_cnt++;
      if (!locked) wr_unlocked++;
      if (first_cyc < 0) begin
        first_cyc = cyc_n; first_x = int'(pix_x); first_y = int'(pix_y);
      end
      last_x = int'(pix_x); last_y = int'(pix_y);
      if (pix_data !== {24{pix_x[0] ^ pix_y[0]}}) data_bad++;
    end
    if (frame_start) fs_cnt++;
    if (err_timing && !err_prev && err_rise_cyc < 0) err_rise_cyc = cyc_n;
    err_prev = err_timing;
    hsync = hs; vsync = vs; valid = v; err_clr = clr;
    {vga_r, vga_g, vga_b} = rgb;
    if (v && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (!hs && hs_prev_drv) last_fall_cyc = cyc_n;
    hs_prev_drv = hs;
  endtask

  task automatic drive_line(input int l, input int len, input int nval,
                            input logic clr, input int lim);
    for (int c = 0; c < len && c < lim; c++) begin
      int x, y;
      logic v, b;
      x = c - H_VSTART; y = l - V_ASTART;
      v = (c >= H_VSTART) && (c < H_VSTART + nval);
      b = x[0] ^ y[0];
      tick(c >= HS_W, l >= V_SYNC, v, {24{b}}, clr && (c == 0));
      if (c == 0) line_cyc0 = cyc_n;
    end
  endtask

  task automatic drive_frame(input int stretch, input int extra, input logic clr);
    for (int l = 0; l < VT; l++) begin
      int len, nval;
      len = HT;
      if (l == stretch) len++;
      nval = 0;
      if (l >= V_ASTART && l < V_ASTART + VA) nval = HA;
      if (l == extra) nval++;
      drive_line(l, len, nval, clr && (l == 1), HT + 1);
      if (l == stretch + 1) stretch_fall_cyc = line_cyc0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; valid = 1'b0; err_clr = 1'b0;
    {vga_r, vga_g, vga_b} = '0;
    repeat (3) @(negedge pclk);
    checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL rst_pix_we: got %b want 0", pix_we); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b want 0", locked); end
    checks++; if (err_timing !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timing); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    checks++; if ({h_total_meas, v_total_meas} !== 20'd0) begin errors++; $display("FAIL rst_meas: got %0d/%0d want 0/0", h_total_meas, v_total_meas); end
    checks++; if ({pix_x, pix_y, pix_data} !== 44'd0) begin errors++; $display("FAIL rst_pix: got %0d %0d %h want 0", pix_x, pix_y, pix_data); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    reset_stats();
    drive_frame(-1, -1, 1'b0);
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_third: got %b want 1", locked); end
    checks++; if (h_total_meas !== 10'd32) begin errors++; $display("FAIL lock_hmeas: got %0d want 32", h_total_meas); end
    checks++; if (v_total_meas !== 10'd10) begin errors++; $display("FAIL lock_vmeas: got %0d want 10", v_total_meas); end
    checks++; if (err_timing !== 1'b0) begin errors++; $display("FAIL lock_err: got %b want 0", err_timing); end
    checks++; if (fs_cnt !== 3) begin errors++; $display("FAIL lock_fs_cnt: got %0d want 3", fs_cnt); end
  endtask

  task automatic test_locked_frame();
    reset_stats();
    drive_frame(-1, -1, 1'b0);
    checks++; if (wr_cnt !== 96) begin errors++; $display("FAIL frm_writes: got %0d want 96", wr_cnt); end
    checks++; if (first_cyc - first_valid_cyc !== 2) begin errors++; $display("FAIL frm_latency: got %0d want 2", first_cyc - first_valid_cyc); end
    checks++; if (first_x !== 0 || first_y !== 0) begin errors++; $display("FAIL frm_first: got %0d,%0d want 0,0", first_x, first_y); end
    checks++; if (last_x !== 15 || last_y !== 5) begin errors++; $display("FAIL frm_last: got %0d,%0d want 15,5", last_x, last_y); end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL frm_data: got %0d bad want 0", data_bad); end
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL frm_fs: got %0d want 1", fs_cnt); end
  endtask

  task automatic test_stretch();
    reset_stats();
    drive_frame(3, -1, 1'b0);
    checks++; if (err_rise_cyc !== stretch_fall_cyc + 2) begin errors++; $display("FAIL str_err_time: got %0d want %0d", err_rise_cyc, stretch_fall_cyc + 2); end
    checks++; if (err_timing !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL str_state: got err=%b lock=%b want 1/0", err_timing, locked); end
    checks++; if (wr_cnt !== 32) begin errors++; $display("FAIL str_writes: got %0d want 32", wr_cnt); end
    drive_frame(-1, -1, 1'b0);
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL str_relock_early: got %b want 0", locked); end
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b1 || err_timing !== 1'b1) begin errors++; $display("FAIL str_relock: got lock=%b err=%b want 1/1", locked, err_timing); end
    drive_frame(-1, -1, 1'b1);
    checks++; if (err_timing !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL str_clr: got err=%b lock=%b want 0/1", err_timing, locked); end
  endtask

  task automatic test_extra_valid();
    reset_stats();
    drive_frame(-1, 4, 1'b0);
    checks++; if (wr_cnt !== 48) begin errors++; $display("FAIL xv_writes: got %0d want 48", wr_cnt); end
    checks++; if (last_x !== 15 || last_y !== 2) begin errors++; $display("FAIL xv_last: got %0d,%0d want 15,2", last_x, last_y); end
    checks++; if (err_timing !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL xv_state: got err=%b lock=%b want 1/0", err_timing, locked); end
  endtask

  task automatic test_hold_hsync();
    drive_frame(-1, -1, 1'b1);
    drive_frame(-1, -1, 1'b0);
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b1 || err_timing !== 1'b0) begin errors++; $display("FAIL hold_pre: got lock=%b err=%b want 1/0", locked, err_timing); end
    reset_stats();
    repeat (1100) tick(1'b1, 1'b1, 1'b0, 24'd0, 1'b0);
    checks++; if (err_rise_cyc !== last_fall_cyc + 1025) begin errors++; $display("FAIL hold_err_time: got %0d want %0d", err_rise_cyc, last_fall_cyc + 1025); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hold_locked: got %b want 0", locked); end
    drive_frame(-1, -1, 1'b0);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL hold_writes: got %0d want 0", wr_cnt); end
  endtask

  task automatic test_reset_mid();
    drive_frame(-1, -1, 1'b0);
    for (int l = 0; l < 3; l++) drive_line(l, HT, (l >= V_ASTART) ? HA : 0, 1'b0, HT);
    drive_line(3, HT, HA, 1'b0, 12);
    checks++; if (locked !== 1'b1 || pix_we !== 1'b1) begin errors++; $display("FAIL mid_pre: got lock=%b we=%b want 1/1", locked, pix_we); end
    #2 reset = 1'b1;
    hsync = 1'b1; vsync = 1'b1; valid = 1'b0; hs_prev_drv = 1'b1;
    #1;
    checks++; if ({pix_we, locked, err_timing, frame_start} !== 4'd0) begin errors++; $display("FAIL mid_flags: got %b want 0000", {pix_we, locked, err_timing, frame_start}); end
    checks++; if ({h_total_meas, v_total_meas, pix_x, pix_y, pix_data} !== 64'd0) begin errors++; $display("FAIL mid_data: got %0d %0d %0d %0d %h want 0", h_total_meas, v_total_meas, pix_x, pix_y, pix_data); end
    @(negedge pclk);
    reset = 1'b0;
    reset_stats();
    drive_frame(-1, -1, 1'b0);
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %b want 0", locked); end
    drive_frame(-1, -1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock: got %b want 1", locked); end
    checks++; if (wr_unlocked !== 0) begin errors++; $display("FAIL we_unlocked: got %0d want 0", wr_unlocked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_locked_frame();
    test_stretch();
    test_extra_valid();
    test_hold_hsync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
